// File: rtl/lfsr_stream_decrypt.sv
// Receive-side LFSR keystream decryptor: XORs each accepted cipher word with the
// current 6-bit LFSR key, advancing the key STEPS_PER_WORD times per word.
module lfsr_stream_decrypt #(
  parameter int unsigned           WIDTH          = 6,
  parameter logic [WIDTH-1:0]      DEFAULT_SEED   = 6'h01,
  parameter int unsigned           STEPS_PER_WORD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             seed_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] key_state,
  output logic [15:0]      word_cnt
);

  typedef enum logic {RUN, ADVANCE} state_t;

  localparam logic [3:0] ADV_INIT = 4'(STEPS_PER_WORD - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0]       adv_q, adv_d;
  logic             rdy;
  logic             accept;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[0] ^ s[1], s[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    adv_d   = adv_q;
    err_d   = seed_load && (seed_in == '0);
    rdy     = 1'b0;

    case (state_q)
      RUN:     rdy = !seed_load && (!valid_q || out_ready);
      ADVANCE: begin
        // A rejected (zero) seed load stalls the extra stepping for that cycle.
        if (!seed_load) begin
          lfsr_d = lfsr_step(lfsr_q);
          adv_d  = adv_q - 4'd1;
          if (adv_q == 4'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    accept = in_valid && rdy;
    if (accept) begin
      data_d  = in_data ^ lfsr_q;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 16'd1;
      lfsr_d  = lfsr_step(lfsr_q);
      if (STEPS_PER_WORD > 1) begin
        state_d = ADVANCE;
        adv_d   = ADV_INIT;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    // Nonzero seed wins over everything but leaves any pending output word alone.
    if (seed_load && (seed_in != '0)) begin
      lfsr_d  = seed_in;
      cnt_d   = '0;
      state_d = RUN;
      adv_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lfsr_q  <= DEFAULT_SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      adv_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
    end
  end

  assign in_ready  = rdy;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign seed_err  = err_q;
  assign key_state = lfsr_q;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Randomized bench for lfsr_stream_decrypt: two instances (1 and 3 key steps per
// word) driven in lockstep and compared against a per-instance keystream model.
module tb_lfsr_stream_decrypt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_load = 1'b0;
  logic [5:0] seed_in = '0;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = '0;
  logic       out_ready = 1'b0;

  logic        rdy [2];
  logic        ov  [2];
  logic        se  [2];
  logic [5:0]  od  [2];
  logic [5:0]  ks  [2];
  logic [15:0] wc  [2];

  int n_tests = 0;
  int n_fail  = 0;

  localparam int STEPS [2] = '{1, 3};

  always #5 clk = ~clk;

  lfsr_stream_decrypt #(.WIDTH(6), .DEFAULT_SEED(6'h01), .STEPS_PER_WORD(1)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .seed_err(se[0]),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .key_state(ks[0]), .word_cnt(wc[0]));

  lfsr_stream_decrypt #(.WIDTH(6), .DEFAULT_SEED(6'h01), .STEPS_PER_WORD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .seed_err(se[1]),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .key_state(ks[1]), .word_cnt(wc[1]));

  // Reference state: current key, pending plaintext, word count, stall cycles left.
  logic [5:0]  m_key [2];
  logic [5:0]  m_data[2];
  logic        m_vld [2];
  logic        m_err [2];
  logic [15:0] m_cnt [2];
  int          m_adv [2];

  function automatic logic [5:0] key_next(input logic [5:0] v);
    return {v[0] ^ v[1], v[5:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_key[k] = 6'h01; m_data[k] = '0; m_vld[k] = 1'b0;
      m_err[k] = 1'b0;  m_cnt[k] = '0;  m_adv[k] = 0;
    end
  endtask

  function automatic logic m_ready(input int k, input logic sl, input logic ordy);
    return !sl && (m_adv[k] == 0) && (!m_vld[k] || ordy);
  endfunction

  // One clock: drive inputs, check outputs from the previous edge, advance the model.
  task automatic cyc(input logic sl, input logic [5:0] sd, input logic iv,
                     input logic [5:0] id, input logic ordy);
    logic acc;
    @(negedge clk);
    seed_load = sl; seed_in = sd; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready%0d", k),  32'(rdy[k]), 32'(m_ready(k, sl, ordy)));
      chk($sformatf("out_valid%0d", k), 32'(ov[k]),  32'(m_vld[k]));
      if (m_vld[k]) chk($sformatf("out_data%0d", k), 32'(od[k]), 32'(m_data[k]));
      chk($sformatf("key_state%0d", k), 32'(ks[k]),  32'(m_key[k]));
      chk($sformatf("word_cnt%0d", k),  32'(wc[k]),  32'(m_cnt[k]));
      chk($sformatf("seed_err%0d", k),  32'(se[k]),  32'(m_err[k]));
    end
    for (int k = 0; k < 2; k++) begin
      acc = iv && m_ready(k, sl, ordy);
      m_err[k] = sl && (sd == 6'd0);
      if (acc) begin
        m_data[k] = id ^ m_key[k];
        m_vld[k]  = 1'b1;
      end else if (m_vld[k] && ordy) begin
        m_vld[k] = 1'b0;
      end
      if (sl) begin
        if (sd != 6'd0) begin
          m_key[k] = sd; m_cnt[k] = '0; m_adv[k] = 0;
        end
      end else if (m_adv[k] > 0) begin
        m_key[k] = key_next(m_key[k]);
        m_adv[k]--;
      end else if (acc) begin
        m_key[k] = key_next(m_key[k]);
        m_cnt[k] = m_cnt[k] + 16'd1;
        m_adv[k] = STEPS[k] - 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_out_valid%0d", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_key%0d", k),       32'(ks[k]), 32'h01);
      chk($sformatf("rst_cnt%0d", k),       32'(wc[k]), 32'd0);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    #12;
    do_reset();

    // Seeded known-answer pair
    cyc(1'b1, 6'b101101, 1'b0, 6'd0, 1'b1);
    cyc(1'b0, 6'd0, 1'b1, 6'b000000, 1'b1);
    cyc(1'b0, 6'd0, 1'b1, 6'b110110, 1'b1);
    chk("kat_out1", 32'(od[0]), 32'b101101);
    chk("kat_key1", 32'(ks[0]), 32'b110110);
    cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
    chk("kat_out2", 32'(od[0]), 32'b000000);
    chk("kat_cnt2", 32'(wc[0]), 32'd2);

    // Backpressure hold, then drain and accept together
    for (int i = 0; i < 5; i++) cyc(1'b0, 6'd0, 1'b1, 6'h2a, 1'b0);
    chk("hold_rdy", 32'(rdy[0]), 32'd0);
    cyc(1'b0, 6'd0, 1'b1, 6'h15, 1'b1);
    chk("drain_acc_rdy", 32'(rdy[0]), 32'd1);

    // Rejected zero seed
    cyc(1'b1, 6'd0, 1'b0, 6'd0, 1'b1);
    cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    chk("seed_err_pulse", 32'(se[0]), 32'd1);
    cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    chk("seed_err_clear", 32'(se[0]), 32'd0);

    // Multi-step instance: two stall cycles, then three steps applied
    cyc(1'b1, 6'b101101, 1'b0, 6'd0, 1'b1);
    cyc(1'b0, 6'd0, 1'b1, 6'h00, 1'b1);
    cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    chk("adv_stall1", 32'(rdy[1]), 32'd0);
    cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    chk("adv_stall2", 32'(rdy[1]), 32'd0);
    cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    chk("adv_key3", 32'(ks[1]), 32'b011101);
    chk("adv_run", 32'(rdy[1]), 32'd1);
    // Seed load aborting ADVANCE
    cyc(1'b0, 6'd0, 1'b1, 6'h07, 1'b1);
    cyc(1'b1, 6'h21, 1'b0, 6'd0, 1'b1);
    cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    chk("abort_key", 32'(ks[1]), 32'h21);
    chk("abort_rdy", 32'(rdy[1]), 32'd1);

    // Full period from seed 1
    cyc(1'b1, 6'h01, 1'b0, 6'd0, 1'b1);
    for (int i = 0; i < 63; i++) cyc(1'b0, 6'd0, 1'b1, 6'($urandom), 1'b1);
    cyc(1'b0, 6'd0, 1'b0, 6'd0, 1'b1);
    chk("period_key", 32'(ks[0]), 32'h01);
    chk("period_cnt", 32'(wc[0]), 32'd63);

    // Random traffic with occasional seed loads and resets
    for (int i = 0; i < 3000; i++) begin
      logic       sl;
      logic [5:0] sd;
      if (i % 700 == 699) do_reset();
      sl = ($urandom_range(0, 15) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      cyc(sl, sd, 1'($urandom), 6'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
